oled_frame_streamer: RTL

OLED_FRAME_STREAMER -- requirements
Module: oled_frame_streamer

---
 rtl/oled_pkg.sv | 30 +++
 rtl/oled_frame_streamer.sv | 119 +++++++++++
 2 files changed

// File: rtl/oled_pkg.sv
// Shared SSD1306 command constants, display defaults and the frame streamer
// state encoding.
package oled_pkg;

  localparam int DEFAULT_WIDTH  = 128;
  localparam int DEFAULT_HEIGHT = 64;

  // Addressing commands used to frame each full-screen transfer.
  localparam logic [7:0] CMD_COL_ADDR  = 8'h21;
  localparam logic [7:0] CMD_PAGE_ADDR = 8'h22;

  // Power-up / init commands shared with the init sequencer.
  localparam logic [7:0] CMD_SET_MEM_MODE = 8'h20;
  localparam logic [7:0] CMD_SET_CONTRAST = 8'h81;
  localparam logic [7:0] CMD_CHARGE_PUMP  = 8'h8D;
  localparam logic [7:0] CMD_DISPLAY_OFF  = 8'hAE;
  localparam logic [7:0] CMD_DISPLAY_ON   = 8'hAF;

  localparam int CMD_SEQ_LEN = 6;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CMD   = 3'd1,
    S_FETCH = 3'd2,
    S_LOAD  = 3'd3,
    S_HOLD  = 3'd4,
    S_DONE  = 3'd5
  } streamer_state_t;

endpackage

// File: rtl/oled_frame_streamer.sv
// Streams one full SSD1306 frame: a column/page address window followed by
// every framebuffer byte, page-major, over a valid/ready byte interface.
module oled_frame_streamer
  import oled_pkg::*;
#(
  parameter  int DISPLAY_WIDTH  = DEFAULT_WIDTH,
  parameter  int DISPLAY_HEIGHT = DEFAULT_HEIGHT,
  localparam int PAGES          = DISPLAY_HEIGHT / 8,
  localparam int FB_BYTES       = DISPLAY_WIDTH * PAGES,
  localparam int ADDR_W         = $clog2(FB_BYTES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              frame_done,
  output logic              fb_rd_en,
  output logic [ADDR_W-1:0] fb_rd_addr,
  input  logic [7:0]        fb_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_byte,
  output logic              out_dc
);

  // Handshake: a byte transfers on a clk edge where out_valid && out_ready;
  // once raised, out_valid/out_byte/out_dc hold until that transfer happens.

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_BYTES - 1);
  localparam logic [2:0]        LAST_CMD  = 3'(CMD_SEQ_LEN - 1);

  streamer_state_t   state, state_next;
  logic [2:0]        cmd_idx;
  logic [ADDR_W-1:0] addr;
  logic              accept;

  function automatic logic [7:0] cmd_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    cmd_byte = CMD_COL_ADDR;
      3'd1:    cmd_byte = 8'h00;
      3'd2:    cmd_byte = 8'(DISPLAY_WIDTH - 1);
      3'd3:    cmd_byte = CMD_PAGE_ADDR;
      3'd4:    cmd_byte = 8'h00;
      3'd5:    cmd_byte = 8'(PAGES - 1);
      default: cmd_byte = 8'h00;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = out_valid && out_ready;
    busy       = (state != S_IDLE);
    frame_done = (state == S_DONE);
    fb_rd_en   = (state == S_FETCH);
    fb_rd_addr = addr;
    case (state)
      S_IDLE:  if (start) state_next = S_CMD;
      S_CMD:   if (accept && cmd_idx == LAST_CMD) state_next = S_FETCH;
      S_FETCH: state_next = S_LOAD;
      S_LOAD:  state_next = S_HOLD;
      S_HOLD:  if (accept) state_next = (addr == LAST_ADDR) ? S_DONE : S_FETCH;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // The output byte is staged one state ahead so out_valid is already high
  // in the first CMD cycle and in every HOLD cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_idx   <= '0;
      addr      <= '0;
      out_valid <= 1'b0;
      out_byte  <= 8'h00;
      out_dc    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cmd_idx   <= '0;
            out_byte  <= cmd_byte(3'd0);
            out_dc    <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        S_CMD: begin
          if (accept) begin
            if (cmd_idx == LAST_CMD) begin
              out_valid <= 1'b0;
              addr      <= '0;
            end else begin
              cmd_idx  <= cmd_idx + 3'd1;
              out_byte <= cmd_byte(cmd_idx + 3'd1);
            end
          end
        end
        S_LOAD: begin
          out_byte  <= fb_rd_data;
          out_dc    <= 1'b1;
          out_valid <= 1'b1;
        end
        S_HOLD: begin
          if (accept) begin
            out_valid <= 1'b0;
            // Terminal address leaves addr in place so the counter never wraps.
            if (addr != LAST_ADDR) addr <= addr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
